// File: rtl/iseq_src_arbiter_pkg.sv
// Shared encodings for the instruction-sequence source arbiter: FSM states and source IDs.
package iseq_src_arbiter_pkg;

   typedef enum logic [2:0] {
      ARB_IDLE      = 3'd0,
      ARB_APP_XFER  = 3'd1,
      ARB_MNT_XFER  = 3'd2,
      ARB_COMMIT    = 3'd3,
      ARB_WAIT_DISP = 3'd4
   } arb_state_t;

   typedef enum logic {
      SRC_APP = 1'b0,
      SRC_MNT = 1'b1
   } src_t;

endpackage

// File: rtl/iseq_src_arbiter.sv
// Grants whole instruction sequences from the host stream or maintenance handler, steers words
// alternately into the two instruction FIFOs, then waits for the dispatcher to drain them.
module iseq_src_arbiter
   import iseq_src_arbiter_pkg::*;
#(
   parameter int IW             = 32,
   parameter int MAX_MNT_STREAK = 4,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             app_en,
   input  logic             app_last,
   input  logic [IW-1:0]    app_instr,
   output logic             app_ack,
   input  logic             mnt_en,
   input  logic             mnt_last,
   input  logic [IW-1:0]    mnt_instr,
   output logic             mnt_ack,
   output logic             instr0_fifo_en,
   output logic             instr1_fifo_en,
   output logic [IW-1:0]    instr_fifo_data,
   input  logic             instr0_fifo_full,
   input  logic             instr1_fifo_full,
   input  logic             dispatcher_busy,
   output logic             process_iseq,
   output logic             grant_app,
   output logic             grant_mnt,
   output logic [CNT_W-1:0] app_seq_cnt,
   output logic [CNT_W-1:0] mnt_seq_cnt
);

   localparam int             SW         = $clog2(MAX_MNT_STREAK + 1);
   localparam logic [SW-1:0]  STREAK_MAX = SW'(MAX_MNT_STREAK);

   arb_state_t        state, state_nxt;
   src_t              src;
   logic              slot;
   logic              busy_seen;
   logic [SW-1:0]     mnt_streak;

   logic              tgt_full;
   logic              app_ack_c, mnt_ack_c, wr_c;
   logic [IW-1:0]     wr_data_c;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      tgt_full  = slot ? instr1_fifo_full : instr0_fifo_full;
      app_ack_c = 1'b0;
      mnt_ack_c = 1'b0;
      wr_c      = 1'b0;
      wr_data_c = '0;
      unique case (state)
         ARB_IDLE: begin
            if (mnt_en && (!app_en || mnt_streak < STREAK_MAX))
               state_nxt = ARB_MNT_XFER;
            else if (app_en)
               state_nxt = ARB_APP_XFER;
         end
         ARB_APP_XFER: begin
            if (app_en && !tgt_full) begin
               app_ack_c = 1'b1;
               wr_c      = 1'b1;
               wr_data_c = app_instr;
               if (app_last) state_nxt = ARB_COMMIT;
            end
         end
         ARB_MNT_XFER: begin
            if (mnt_en && !tgt_full) begin
               mnt_ack_c = 1'b1;
               wr_c      = 1'b1;
               wr_data_c = mnt_instr;
               if (mnt_last) state_nxt = ARB_COMMIT;
            end
         end
         ARB_COMMIT:    state_nxt = ARB_WAIT_DISP;
         ARB_WAIT_DISP: if (busy_seen && !dispatcher_busy) state_nxt = ARB_IDLE;
         default:       state_nxt = ARB_IDLE;
      endcase
   end

   // Combinational outputs are forced low while reset is asserted so nothing leaks into the FIFOs.
   assign app_ack         = rst & app_ack_c;
   assign mnt_ack         = rst & mnt_ack_c;
   assign instr0_fifo_en  = rst & wr_c & ~slot;
   assign instr1_fifo_en  = rst & wr_c &  slot;
   assign instr_fifo_data = rst ? wr_data_c : '0;
   assign grant_app       = rst & (state == ARB_APP_XFER);
   assign grant_mnt       = rst & (state == ARB_MNT_XFER);
   assign process_iseq    = rst & (state == ARB_COMMIT);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ARB_IDLE;
         src        <= SRC_APP;
         slot       <= 1'b0;
         busy_seen  <= 1'b0;
         mnt_streak <= '0;
      end else begin
         state <= state_nxt;
         if (state == ARB_IDLE && state_nxt != ARB_IDLE) begin
            slot <= 1'b0;
            src  <= (state_nxt == ARB_MNT_XFER) ? SRC_MNT : SRC_APP;
         end else if (wr_c) begin
            slot <= ~slot;
         end
         if (state == ARB_COMMIT) begin
            busy_seen <= 1'b0;
            if (src == SRC_APP)
               mnt_streak <= '0;
            else if (mnt_streak != STREAK_MAX)
               mnt_streak <= mnt_streak + SW'(1);
         end else if (state == ARB_WAIT_DISP && dispatcher_busy) begin
            busy_seen <= 1'b1;
         end
      end
   end

   // Completed-sequence counters saturate at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (!rst) begin
         app_seq_cnt <= '0;
         mnt_seq_cnt <= '0;
      end else if (state == ARB_COMMIT) begin
         if (src == SRC_APP && app_seq_cnt != '1) app_seq_cnt <= app_seq_cnt + CNT_W'(1);
         if (src == SRC_MNT && mnt_seq_cnt != '1) mnt_seq_cnt <= mnt_seq_cnt + CNT_W'(1);
      end
   end

endmodule
